contador_comparador_busca: RTL and testbench

Parametrised datapath-plus-control block that generalises the fixed 4-bit counter/comparator pair into an N-bit modulo-M counter with load and a comparator against the switch value `chaves`. It adds an autonomous search mode: on `iniciar`, the counter sweeps upward from its current value until it equals `chaves` or reaches the top of its range, then reports the result. It sits between the switch inputs and the display/LED outputs of the experiment board, and serves as the datapath core for the next experiment's controller.

---
 rtl/contador_comparador_busca.sv | 104 ++++++++++
 tb/tb_contador_comparador_busca.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_comparador_busca.sv
// N-bit modulo-MODULO counter with load, live comparator against chaves and an autonomous upward search FSM.
// Compare flags and fim are combinational on Q; Q and state update one edge after their inputs; no backpressure.
module contador_comparador_busca #(
    parameter int N      = 4,
    parameter int MODULO = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         carrega,
    input  logic         conta,
    input  logic         iniciar,
    input  logic [N-1:0] chaves,
    output logic [N-1:0] contagem,
    output logic         menor,
    output logic         maior,
    output logic         igual,
    output logic         fim,
    output logic         pronto,
    output logic         achou,
    output logic [1:0]   db_estado
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] BUSCA  = 2'd1;
    localparam logic [1:0] ACHOU  = 2'd2;
    localparam logic [1:0] FALHA  = 2'd3;

    localparam logic [N-1:0] Q_MAX   = N'(MODULO - 1);
    localparam logic [N:0]   MOD_EXT = (N + 1)'(MODULO);

    logic [N-1:0] cnt_q, cnt_d;
    logic [1:0]   estado_q, estado_d;
    logic         no_topo;
    logic         habilita;

    assign no_topo = (cnt_q == Q_MAX);
    assign igual   = (cnt_q == chaves);
    assign menor   = (cnt_q <  chaves);
    assign maior   = (cnt_q >  chaves);
    assign fim     = no_topo & conta;

    // During the search the counter climbs on its own and must stop at the top instead of wrapping.
    always_comb begin
        habilita = conta;
        if (estado_q == BUSCA) begin
            habilita = ~igual & ~no_topo;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (carrega) begin
            if ({1'b0, chaves} >= MOD_EXT) begin
                cnt_d = Q_MAX;
            end else begin
                cnt_d = chaves;
            end
        end else if (habilita) begin
            cnt_d = no_topo ? '0 : cnt_q + 1'b1;
        end
    end

    // Transitions look at the pre-edge Q, so a load during the search is tested on the following edge.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (iniciar) estado_d = BUSCA;
            end
            BUSCA: begin
                if (igual) begin
                    estado_d = ACHOU;
                end else if (no_topo) begin
                    estado_d = FALHA;
                end
            end
            default: begin
                if (iniciar) estado_d = BUSCA;
            end
        endcase
        if (zera) begin
            estado_d = OCIOSO;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            estado_q <= OCIOSO;
        end else begin
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
        end
    end

    assign contagem  = cnt_q;
    assign pronto    = estado_q[1];
    assign achou     = (estado_q == ACHOU);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_contador_comparador_busca.sv
// Scoreboarded directed bench: instance A is N=4/MODULO=10, instance B is N=6/MODULO=40.
module tb_contador_comparador_busca;

    logic clock;
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic       rst[2], zera[2], carrega[2], conta[2], iniciar[2];
    logic [3:0] ch_a;
    logic [5:0] ch_b;
    logic [3:0] cnt_a;
    logic [5:0] cnt_b;
    logic [1:0] men, mai, igu, fim, pro, ach;
    logic [1:0] est_a, est_b;

    contador_comparador_busca #(.N(4), .MODULO(10)) dut_a (
        .clock(clock), .reset(rst[0]), .zera(zera[0]), .carrega(carrega[0]),
        .conta(conta[0]), .iniciar(iniciar[0]), .chaves(ch_a), .contagem(cnt_a),
        .menor(men[0]), .maior(mai[0]), .igual(igu[0]), .fim(fim[0]),
        .pronto(pro[0]), .achou(ach[0]), .db_estado(est_a)
    );

    contador_comparador_busca #(.N(6), .MODULO(40)) dut_b (
        .clock(clock), .reset(rst[1]), .zera(zera[1]), .carrega(carrega[1]),
        .conta(conta[1]), .iniciar(iniciar[1]), .chaves(ch_b), .contagem(cnt_b),
        .menor(men[1]), .maior(mai[1]), .igual(igu[1]), .fim(fim[1]),
        .pronto(pro[1]), .achou(ach[1]), .db_estado(est_b)
    );

    int          total = 0;
    int          bad   = 0;
    int          q_sel[$];
    string       q_name[$];
    logic [13:0] q_exp[$];
    event        smp;

    // Expected vector: {Q, menor, maior, igual, fim, pronto, achou, estado}
    function automatic logic [13:0] expect_vec(int sel, int q, int est);
        int         c;
        int         m;
        logic [5:0] qv;
        logic [1:0] ev;
        c  = (sel != 0) ? int'(ch_b) : int'(ch_a);
        m  = (sel != 0) ? 40 : 10;
        qv = q[5:0];
        ev = est[1:0];
        return {qv, q < c, q > c, q == c, (q == m - 1) && conta[sel], est >= 2, est == 2, ev};
    endfunction

    function automatic logic [13:0] actual_vec(int sel);
        return {(sel != 0) ? cnt_b : {2'b00, cnt_a}, men[sel], mai[sel], igu[sel],
                fim[sel], pro[sel], ach[sel], (sel != 0) ? est_b : est_a};
    endfunction

    task automatic push(int sel, string name, int q, int est);
        q_sel.push_back(sel);
        q_name.push_back(name);
        q_exp.push_back(expect_vec(sel, q, est));
    endtask

    task automatic tick(int sel, string name, int q, int est);
        @(posedge clock);
        #1;
        push(sel, name, q, est);
        @(negedge clock);
        #1;
    endtask

    task automatic look(int sel, string name, int q, int est);
        push(sel, name, q, est);
        ->smp;
        #1;
    endtask

    always @(negedge clock) ->smp;

    initial begin
        forever begin
            @(smp);
            while (q_exp.size() > 0) begin
                int          s;
                string       n;
                logic [13:0] e;
                logic [13:0] a;
                s = q_sel.pop_front();
                n = q_name.pop_front();
                e = q_exp.pop_front();
                a = actual_vec(s);
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s dut=%0d: got q=%0d flags=%b st=%0d, want q=%0d flags=%b st=%0d",
                             n, s, a[13:8], a[7:2], a[1:0], e[13:8], e[7:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; zera[k] = 1'b0; carrega[k] = 1'b0; conta[k] = 1'b0; iniciar[k] = 1'b0;
        end
        ch_a = 4'd0;
        ch_b = 6'd0;
        #2;
        look(0, "reset_a", 0, 0);
        look(1, "reset_b", 0, 0);
        @(negedge clock);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Count up to 7, then reset asynchronously mid-cycle
        conta[0] = 1'b1;
        for (int i = 1; i <= 7; i++) tick(0, "count", i, 0);
        rst[0] = 1'b1;
        #1;
        look(0, "async_rst", 0, 0);
        rst[0]   = 1'b0;
        conta[0] = 1'b0;

        ch_a = 4'd3;
        look(0, "cmp_lt", 0, 0);
        carrega[0] = 1'b1;
        tick(0, "load3", 3, 0);
        ch_a = 4'd12;
        tick(0, "load_sat", 9, 0);

        // Wrap: load 8 with conta high (load wins), then count through 9 -> 0
        ch_a = 4'd8;
        conta[0] = 1'b1;
        tick(0, "load8", 8, 0);
        carrega[0] = 1'b0;
        ch_a = 4'd0;
        tick(0, "wrap_top", 9, 0);
        tick(0, "wrap_zero", 0, 0);
        tick(0, "wrap_one", 1, 0);
        conta[0] = 1'b0;

        // Successful search 2 -> 6, conta high during BUSCA must be ignored
        ch_a = 4'd2;
        carrega[0] = 1'b1;
        tick(0, "load2", 2, 0);
        carrega[0] = 1'b0;
        ch_a = 4'd6;
        iniciar[0] = 1'b1;
        tick(0, "ok_start", 2, 1);
        iniciar[0] = 1'b0;
        conta[0]   = 1'b1;
        for (int i = 3; i <= 6; i++) tick(0, "ok_climb", i, 1);
        tick(0, "ok_achou", 6, 2);
        conta[0] = 1'b0;
        tick(0, "ok_hold", 6, 2);
        iniciar[0] = 1'b1;
        tick(0, "reinit", 6, 1);
        iniciar[0] = 1'b0;
        tick(0, "reinit_achou", 6, 2);

        // Failed search: target below start, then target beyond range
        ch_a = 4'd5;
        carrega[0] = 1'b1;
        tick(0, "load5", 5, 2);
        carrega[0] = 1'b0;
        ch_a = 4'd2;
        iniciar[0] = 1'b1;
        tick(0, "fail_start", 5, 1);
        iniciar[0] = 1'b0;
        for (int i = 6; i <= 9; i++) tick(0, "fail_climb", i, 1);
        tick(0, "falha", 9, 3);
        ch_a = 4'd5;
        carrega[0] = 1'b1;
        tick(0, "reload5", 5, 3);
        carrega[0] = 1'b0;
        ch_a = 4'd13;
        iniciar[0] = 1'b1;
        tick(0, "fail13_start", 5, 1);
        iniciar[0] = 1'b0;
        for (int i = 6; i <= 9; i++) tick(0, "fail13_climb", i, 1);
        tick(0, "falha13", 9, 3);

        // zera beats iniciar
        zera[0] = 1'b1;
        iniciar[0] = 1'b1;
        tick(0, "zera_init", 0, 0);
        zera[0] = 1'b0;
        iniciar[0] = 1'b0;

        // Load of the target during BUSCA
        ch_a = 4'd8;
        iniciar[0] = 1'b1;
        tick(0, "ld_start", 0, 1);
        iniciar[0] = 1'b0;
        tick(0, "ld_climb", 1, 1);
        carrega[0] = 1'b1;
        tick(0, "ld_busca", 8, 1);
        carrega[0] = 1'b0;
        tick(0, "ld_achou", 8, 2);

        // Wide instance: search 0 -> 39 takes 40 edges
        ch_b = 6'd39;
        iniciar[1] = 1'b1;
        tick(1, "b_start", 0, 1);
        iniciar[1] = 1'b0;
        for (int i = 1; i <= 39; i++) tick(1, "b_climb", i, 1);
        tick(1, "b_achou", 39, 2);

        zera[1] = 1'b1;
        tick(1, "b_zera", 0, 0);
        zera[1] = 1'b0;
        ch_b = 6'd50;
        iniciar[1] = 1'b1;
        tick(1, "b_fstart", 0, 1);
        iniciar[1] = 1'b0;
        for (int i = 1; i <= 39; i++) tick(1, "b_fclimb", i, 1);
        tick(1, "b_falha", 39, 3);

        zera[1] = 1'b1;
        tick(1, "b_zera2", 0, 0);
        zera[1] = 1'b0;
        ch_b = 6'd38;
        carrega[1] = 1'b1;
        tick(1, "b_load38", 38, 0);
        carrega[1] = 1'b0;
        conta[1] = 1'b1;
        tick(1, "b_top", 39, 0);
        tick(1, "b_wrap", 0, 0);
        tick(1, "b_one", 1, 0);
        conta[1] = 1'b0;
        ch_b = 6'd45;
        carrega[1] = 1'b1;
        tick(1, "b_sat", 39, 0);
        carrega[1] = 1'b0;

        @(negedge clock);
        #1;
        total++;
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending checks, want 0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
